bitwise_logic_unit: RTL and testbench

- Parametrised successor to the fixed 32-bit bitwise AND.
- Adds eight selectable bitwise ops, a one-stage registered pipeline with valid/ready handshake, zero and all-ones flags, and a multi-beat accumulate (reduce) mode.
- Feeds the ALU result mux; the accumulate mode serves mask-building and reduction sequences.

---
 rtl/bitwise_logic_unit.sv | 151 +++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// Bitwise logic unit: eight selectable ops plus a multi-beat accumulate (reduce) mode.
// Latency: one cycle from an accepted result-producing beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; the output register holds while stalled.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] beats
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (o)
            OP_AND:  apply_op = a & b;
            OP_OR:   apply_op = a | b;
            OP_XOR:  apply_op = a ^ b;
            OP_NAND: apply_op = ~(a & b);
            OP_NOR:  apply_op = ~(a | b);
            OP_XNOR: apply_op = ~(a ^ b);
            OP_ANDN: apply_op = a & ~b;
            default: apply_op = a;
        endcase
    endfunction

    // The fold never inverts; inverting ops apply their NOT only when the packet is emitted.
    function automatic logic [WIDTH-1:0] fold(input logic [2:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (o)
            OP_AND, OP_NAND: fold = a & b;
            OP_OR,  OP_NOR:  fold = a | b;
            OP_XOR, OP_XNOR: fold = a ^ b;
            OP_ANDN:         fold = a & ~b;
            default:         fold = b;
        endcase
    endfunction

    function automatic logic is_inv(input logic [2:0] o);
        is_inv = (o == OP_NAND) || (o == OP_NOR) || (o == OP_XNOR);
    endfunction

    logic [0:0]       state_q, state_nxt;
    logic [2:0]       op_q, op_nxt;
    logic [WIDTH-1:0] acc_q, acc_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0] fold_val;
    logic             accept;
    logic             emit;
    logic [WIDTH-1:0] emit_dat;
    logic [CNT_W-1:0] emit_beats;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign fold_val = fold(op_q, acc_q, x);

    always_comb begin
        state_nxt  = state_q;
        op_nxt     = op_q;
        acc_nxt    = acc_q;
        cnt_nxt    = cnt_q;
        emit       = 1'b0;
        emit_dat   = '0;
        emit_beats = '0;
        if (accept) begin
            if (state_q == IDLE) begin
                if (!acc) begin
                    emit       = 1'b1;
                    emit_dat   = apply_op(op, x, y);
                    emit_beats = CNT_W'(1);
                end else begin
                    op_nxt  = op;
                    acc_nxt = x;
                    if (last) begin
                        emit       = 1'b1;
                        emit_dat   = is_inv(op) ? ~x : x;
                        emit_beats = CNT_W'(1);
                    end else begin
                        state_nxt = ACCUM;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end else begin
                acc_nxt = fold_val;
                cnt_nxt = cnt_inc;
                if (last) begin
                    emit       = 1'b1;
                    emit_dat   = is_inv(op_q) ? ~fold_val : fold_val;
                    emit_beats = cnt_inc;
                    state_nxt  = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            f         <= '0;
            zero      <= 1'b1;
            ones      <= 1'b0;
            beats     <= '0;
        end else begin
            state_q <= state_nxt;
            op_q    <= op_nxt;
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_nxt;
            // A consumed result is replaced in the same edge when a new one is emitted.
            if (emit) begin
                out_valid <= 1'b1;
                f         <= emit_dat;
                zero      <= (emit_dat == '0);
                ones      <= (&emit_dat);
                beats     <= emit_beats;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed, table-driven bench for bitwise_logic_unit, plus a narrow instance for counter saturation.
module tb_bitwise_logic_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, acc, last, out_valid, out_ready, zero, ones;
    logic [31:0] x, y, f;
    logic [2:0]  op;
    logic [7:0]  beats;

    logic        n_in_valid, n_in_ready, n_acc, n_last, n_out_valid, n_out_ready, n_zero, n_ones;
    logic [7:0]  n_x, n_y, n_f;
    logic [2:0]  n_op;
    logic [1:0]  n_beats;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .acc(acc), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .zero(zero), .ones(ones), .beats(beats)
    );

    bitwise_logic_unit #(.WIDTH(8), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .x(n_x), .y(n_y), .op(n_op), .acc(n_acc), .last(n_last),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .f(n_f), .zero(n_zero), .ones(n_ones), .beats(n_beats)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] f;
        logic        zero;
        logic        ones;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic ac, input logic l);
        in_valid = v;
        op       = o;
        x        = a;
        y        = b;
        acc      = ac;
        last     = l;
    endtask

    vec_t vecs[10];
    logic [31:0] bp_x[3];

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        n_in_valid = 1'b0; n_x = '0; n_y = '0; n_op = '0; n_acc = 1'b0; n_last = 1'b0;
        n_out_ready = 1'b1;

        vecs[0] = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[2] = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
        vecs[3] = '{3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0};
        vecs[4] = '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0};
        vecs[5] = '{3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0, 1'b0};
        vecs[6] = '{3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0, 1'b0};
        vecs[7] = '{3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 1'b0};
        vecs[8] = '{3'b000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[9] = '{3'b101, 32'hA5A55A5A, 32'hA5A55A5A, 32'hFFFFFFFF, 1'b0, 1'b1};
        bp_x[0] = 32'h2; bp_x[1] = 32'h4; bp_x[2] = 32'h8;

        tick;
        tick;
        check("reset out_valid", {31'b0, out_valid}, 32'h0);
        check("reset f", f, 32'h0);
        check("reset zero", {31'b0, zero}, 32'h1);
        check("reset ones", {31'b0, ones}, 32'h0);
        check("reset beats", {24'b0, beats}, 32'h0);
        check("reset in_ready", {31'b0, in_ready}, 32'h1);
        rst = 1'b0;

        // Back-to-back single-beat ops: each result appears one cycle after its beat.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].x, vecs[i].y, 1'b0, 1'b0);
            tick;
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("vec%0d f", i), f, vecs[i].f);
            check($sformatf("vec%0d zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
            check($sformatf("vec%0d ones", i), {31'b0, ones}, {31'b0, vecs[i].ones});
            check($sformatf("vec%0d beats", i), {24'b0, beats}, 32'h1);
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check("drain out_valid", {31'b0, out_valid}, 32'h0);

        // NAND accumulate; op input switched to OR mid-packet must be ignored.
        drive(1'b1, 3'b011, 32'hFFFF0000, 32'h0, 1'b1, 1'b0);
        tick;
        check("nand beat1 out_valid", {31'b0, out_valid}, 32'h0);
        drive(1'b1, 3'b001, 32'hFF00FF00, 32'h0, 1'b0, 1'b0);
        tick;
        check("nand beat2 out_valid", {31'b0, out_valid}, 32'h0);
        drive(1'b1, 3'b001, 32'hF0F0F0F0, 32'h0, 1'b0, 1'b1);
        tick;
        check("nand out_valid", {31'b0, out_valid}, 32'h1);
        check("nand f", f, 32'h0FFFFFFF);
        check("nand beats", {24'b0, beats}, 32'h3);
        check("nand zero", {31'b0, zero}, 32'h0);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check("nand single result", {31'b0, out_valid}, 32'h0);

        // Backpressure: a pending result stalls the input and holds the output.
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h1, 32'h1, 1'b0, 1'b0);
        tick;
        check("bp first f", f, 32'h1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 3'b000, bp_x[0], 32'hFFFFFFFF, 1'b0, 1'b0);
            #1;
            check($sformatf("bp stall%0d in_ready", c), {31'b0, in_ready}, 32'h0);
            tick;
            check($sformatf("bp stall%0d out_valid", c), {31'b0, out_valid}, 32'h1);
            check($sformatf("bp stall%0d f", c), f, 32'h1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b000, bp_x[i], 32'hFFFFFFFF, 1'b0, 1'b0);
            tick;
            check($sformatf("bp drain%0d out_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("bp drain%0d f", i), f, bp_x[i]);
        end
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;
        check("bp empty", {31'b0, out_valid}, 32'h0);

        // Reset in the middle of an OR packet discards the partial accumulation.
        drive(1'b1, 3'b001, 32'h000000A0, 32'h0, 1'b1, 1'b0);
        tick;
        drive(1'b1, 3'b001, 32'h0000000B, 32'h0, 1'b0, 1'b0);
        tick;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst f", f, 32'h0);
        check("midrst beats", {24'b0, beats}, 32'h0);
        #2 rst = 1'b0;
        drive(1'b1, 3'b001, 32'h5, 32'h0, 1'b1, 1'b1);
        tick;
        check("post rst out_valid", {31'b0, out_valid}, 32'h1);
        check("post rst f", f, 32'h5);
        check("post rst beats", {24'b0, beats}, 32'h1);
        drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        tick;

        // Narrow instance: 5-beat XOR packet saturates a 2-bit beat counter.
        for (int i = 0; i < 5; i++) begin
            n_in_valid = 1'b1;
            n_op       = 3'b010;
            n_x        = 8'(1 << i);
            n_acc      = (i == 0);
            n_last     = (i == 4);
            tick;
            if (i < 4) check($sformatf("sat beat%0d out_valid", i), {31'b0, n_out_valid}, 32'h0);
        end
        n_in_valid = 1'b0;
        check("sat out_valid", {31'b0, n_out_valid}, 32'h1);
        check("sat f", {24'b0, n_f}, 32'h1F);
        check("sat beats", {30'b0, n_beats}, 32'h3);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
